// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack arbiter and sequencer for a single-port synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    state_t            state_q, state_d;
    logic              we_q, we_d, grant_q, grant_d, win, tie;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q;
    assign tie = ~ptr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= 1'b1;
        else if (state_q == IDLE && (req0 || req1)) ptr_q <= win;
`else
    assign tie = 1'b0;
`endif
    assign win = (req0 && req1) ? tie : req1;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                grant_d = win;
                we_d    = win ? we1 : we0;
                addr_d  = win ? addr1 : addr0;
                wdata_d = win ? wdata1 : wdata0;
                state_d = ACCESS;
            end
            ACCESS: begin
                state_d = (LAT == 1) ? RESP : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end

    // Address/data stay on the latched values outside ACCESS; the strobes gate them.
    assign busy      = state_q != IDLE;
    assign grant     = grant_q;
    assign mem_read  = state_q == ACCESS && !we_q;
    assign mem_write = state_q == ACCESS && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack0      = state_q == RESP && !grant_q;
    assign ack1      = state_q == RESP && grant_q;
    assign rdata0    = (ack0 && !we_q) ? mem_rdata : '0;
    assign rdata1    = (ack1 && !we_q) ? mem_rdata : '0;
endmodule
